wb_alarm_sched: RTL and testbench

Wishbone-attached microsecond time base and alarm scheduler for the softcore I/O space. Owns a 64-bit free-running microsecond counter and NUM_CH independent countdown channels, one-shot or periodic. Sets per-channel status bits when a channel expires and drives a level interrupt line to the core. Sits on the same pipelined Wishbone I/O bus as the other wb_iodevice slaves.

---
 rtl/wb_alarm_sched.sv | 204 ++++++++++++++++++++
 tb/tb_wb_alarm_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_alarm_sched.sv
// Wishbone microsecond time base with NUM_CH one-shot/periodic countdown alarms.
// Registered ack one cycle after accept, never stalls outside reset; o_irq = |(STATUS & IRQ_EN).
module wb_alarm_sched #(
  parameter int          CLOCK_FREQ = 50_000_000,
  parameter int          NUM_CH     = 4,
  parameter logic [63:0] NOW_INIT   = 64'd0
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [29:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_data,
  output logic        o_irq
);

  localparam int COUNTER_TOP = CLOCK_FREQ / 1_000_000;
  localparam int PW          = (COUNTER_TOP > 1) ? $clog2(COUNTER_TOP) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(COUNTER_TOP - 1);

  localparam logic [4:0] A_NOW_LO = 5'd0;
  localparam logic [4:0] A_NOW_HI = 5'd1;
  localparam logic [4:0] A_STATUS = 5'd2;
  localparam logic [4:0] A_IRQ_EN = 5'd3;

  localparam logic [1:0] R_CTRL   = 2'd0;
  localparam logic [1:0] R_RELOAD = 2'd1;
  localparam logic [1:0] R_COUNT  = 2'd2;

  logic              accept;
  logic              wr_en;
  logic              rd_en;
  logic [4:0]        addr;
  logic              ack_q;
  logic [PW-1:0]     prescaler;
  logic              tick;
  logic [63:0]       now;
  logic [31:0]       now_hi_snap;
  logic [NUM_CH-1:0] status;
  logic [NUM_CH-1:0] irq_en;
  logic [NUM_CH-1:0] expire_vec;
  logic [NUM_CH-1:0] ctrl_wr;
  logic [NUM_CH-1:0] reload_wr;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] ch_per;
  logic [31:0]       ch_reload [NUM_CH];
  logic [31:0]       ch_count  [NUM_CH];
  logic [31:0]       rd_mux;
  logic              unused_bits;

  assign unused_bits = ^{i_wb_sel, i_wb_addr[29:5]};

  assign o_wb_stall = !i_reset_n;
  assign accept     = i_wb_cyc & i_wb_stb & !o_wb_stall;
  assign wr_en      = accept & i_wb_we;
  assign rd_en      = accept & !i_wb_we;
  assign addr       = i_wb_addr[4:0];

  // A pending ack is dropped if the master abandons the cycle.
  assign o_wb_ack = ack_q & i_wb_cyc;
  assign o_irq    = |(status & irq_en);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ack_q     <= 1'b0;
      o_wb_data <= 32'd0;
    end else begin
      ack_q <= accept;
      if (rd_en) begin
        o_wb_data <= rd_mux;
      end
    end
  end

  assign tick = (prescaler == PS_LAST);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      prescaler <= '0;
      now       <= NOW_INIT;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        now <= now + 64'd1;
      end
    end
  end

  // Reading NOW_LO captures the upper half so a following NOW_HI read is coherent.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      now_hi_snap <= 32'd0;
    end else if (rd_en && addr == A_NOW_LO) begin
      now_hi_snap <= now[63:32];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      status <= '0;
      irq_en <= '0;
    end else begin
      if (wr_en && addr == A_STATUS) begin
        status <= (status & ~i_wb_data[NUM_CH-1:0]) | expire_vec;
      end else begin
        status <= status | expire_vec;
      end
      if (wr_en && addr == A_IRQ_EN) begin
        irq_en <= i_wb_data[NUM_CH-1:0];
      end
    end
  end

  always_comb begin
    ctrl_wr   = '0;
    reload_wr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_en && addr[4:2] == 3'(c + 2)) begin
        ctrl_wr[c]   = (addr[1:0] == R_CTRL);
        reload_wr[c] = (addr[1:0] == R_RELOAD);
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic        en;
    logic        per;
    logic [31:0] reload;
    logic [31:0] count;
    logic        expire;

    assign expire        = tick & en & (count == 32'd1);
    assign expire_vec[c] = expire;
    assign ch_en[c]      = en;
    assign ch_per[c]     = per;
    assign ch_reload[c]  = reload;
    assign ch_count[c]   = count;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        en     <= 1'b0;
        per    <= 1'b0;
        reload <= 32'd0;
        count  <= 32'd0;
      end else begin
        if (reload_wr[c]) begin
          reload <= i_wb_data;
        end
        if (ctrl_wr[c]) begin
          per <= i_wb_data[1];
        end
        if (ctrl_wr[c] && i_wb_data[0] && !en) begin
          en    <= 1'b1;
          count <= reload;
        end else begin
          // COUNT==0 while enabled never matches here, so the channel just idles.
          if (expire) begin
            if (per) begin
              count <= reload;
              if (reload == 32'd0) begin
                en <= 1'b0;
              end
            end else begin
              count <= 32'd0;
              en    <= 1'b0;
            end
          end else if (tick && en && count > 32'd1) begin
            count <= count - 32'd1;
          end
          if (ctrl_wr[c] && !i_wb_data[0]) begin
            en <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (addr)
      A_NOW_LO: rd_mux = now[31:0];
      A_NOW_HI: rd_mux = now_hi_snap;
      A_STATUS: rd_mux = 32'(status);
      A_IRQ_EN: rd_mux = 32'(irq_en);
      default:  rd_mux = 32'd0;
    endcase
    for (int c = 0; c < NUM_CH; c++) begin
      if (addr[4:2] == 3'(c + 2)) begin
        case (addr[1:0])
          R_CTRL:   rd_mux = {30'd0, ch_per[c], ch_en[c]};
          R_RELOAD: rd_mux = ch_reload[c];
          R_COUNT:  rd_mux = ch_count[c];
          default:  rd_mux = 32'd0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_alarm_sched.sv
// Directed bench for wb_alarm_sched at 4 MHz (4 cycles per microsecond tick).
// NOW starts just below the 32-bit wrap so the LO/HI snapshot can be exercised.
module tb_wb_alarm_sched;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_wb_cyc = 1'b0;
  logic        i_wb_stb = 1'b0;
  logic        i_wb_we = 1'b0;
  logic [29:0] i_wb_addr = '0;
  logic [31:0] i_wb_data = '0;
  logic [3:0]  i_wb_sel = 4'hF;
  logic        o_wb_ack;
  logic        o_wb_stall;
  logic [31:0] o_wb_data;
  logic        o_irq;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_cnt = 0;

  wb_alarm_sched #(
    .CLOCK_FREQ(4_000_000),
    .NUM_CH    (4),
    .NOW_INIT  (64'h0000_0000_FFFF_FFF0)
  ) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_wb_cyc  (i_wb_cyc),
    .i_wb_stb  (i_wb_stb),
    .i_wb_we   (i_wb_we),
    .i_wb_addr (i_wb_addr),
    .i_wb_data (i_wb_data),
    .i_wb_sel  (i_wb_sel),
    .o_wb_ack  (o_wb_ack),
    .o_wb_stall(o_wb_stall),
    .o_wb_data (o_wb_data),
    .o_irq     (o_irq)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; request is accepted at the next rising edge and
  // the ack/data are sampled on the falling edge after that.
  task automatic bus(input logic we, input logic [4:0] a, input logic [31:0] d,
                     output logic [31:0] rd);
    i_wb_cyc  = 1'b1;
    i_wb_stb  = 1'b1;
    i_wb_we   = we;
    i_wb_addr = {25'd0, a};
    i_wb_data = d;
    @(negedge i_clk);
    chk("ack", o_wb_ack, 1);
    rd = o_wb_data;
    i_wb_cyc = 1'b0;
    i_wb_stb = 1'b0;
    i_wb_we  = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus(1'b1, a, d, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus(1'b0, a, 32'd0, v);
    chk(tag, v, exp);
  endtask

  task automatic wait_irq(input string tag, input int limit, output int n, output int at);
    n = 0;
    while (!o_irq && n < limit) begin
      @(negedge i_clk);
      n++;
    end
    chk({tag, " irq seen"}, o_irq, 1);
    at = cyc_cnt;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic        found;
    int          n;
    int          x1;
    int          x2;

    repeat (3) @(negedge i_clk);
    chk("rst ack", o_wb_ack, 0);
    chk("rst irq", o_irq, 0);
    chk("rst data", o_wb_data, 0);
    chk("rst stall", o_wb_stall, 1);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    chk("stall after rst", o_wb_stall, 0);

    rd_chk("rst now_hi", 5'd1, 32'd0);
    rd_chk("rst status", 5'd2, 32'd0);
    rd_chk("rst irq_en", 5'd3, 32'd0);
    rd_chk("rst ctrl0", 5'd8, 32'd0);
    rd_chk("rst reload0", 5'd9, 32'd0);
    rd_chk("rst count0", 5'd10, 32'd0);

    // NOW coherency across the 32-bit wrap
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      bus(1'b0, 5'd0, 32'd0, v);
      if (v == 32'hFFFF_FFFF) found = 1'b1;
    end
    chk("now_lo reaches ffffffff", found, 1);
    repeat (10) @(negedge i_clk);
    rd_chk("now_hi snapshot before wrap", 5'd1, 32'd0);
    bus(1'b0, 5'd0, 32'd0, v);
    rd_chk("now_hi snapshot after wrap", 5'd1, 32'd1);

    // One-shot on channel 0
    wr(5'd3, 32'd1);
    wr(5'd9, 32'd3);
    wr(5'd8, 32'd1);
    wait_irq("oneshot", 40, n, x1);
    chk("oneshot latency 9..12", (n >= 9 && n <= 12), 1);
    rd_chk("oneshot count0", 5'd10, 32'd0);
    rd_chk("oneshot ctrl0", 5'd8, 32'd0);
    rd_chk("oneshot status", 5'd2, 32'd1);
    wr(5'd2, 32'd1);
    chk("oneshot w1c irq", o_irq, 0);
    rd_chk("oneshot status cleared", 5'd2, 32'd0);

    // Periodic on channel 1
    wr(5'd3, 32'd2);
    wr(5'd13, 32'd2);
    wr(5'd12, 32'd3);
    wait_irq("per1", 40, n, x1);
    wr(5'd2, 32'd2);
    chk("per w1c irq", o_irq, 0);
    wait_irq("per2", 20, n, x2);
    chk("per period", x2 - x1, 8);
    n = 0;
    while (cyc_cnt != x2 + 7 && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    wr(5'd2, 32'd2);
    rd_chk("per set beats w1c", 5'd2, 32'd2);
    chk("per irq after race", o_irq, 1);
    wr(5'd12, 32'd0);
    wr(5'd2, 32'hF);
    rd_chk("per status cleared", 5'd2, 32'd0);
    rd_chk("irq_en readback", 5'd3, 32'd2);

    // Back-to-back pipelined strobes
    i_wb_cyc  = 1'b1;
    i_wb_stb  = 1'b1;
    i_wb_we   = 1'b1;
    i_wb_addr = 30'd3;
    i_wb_data = 32'hF;
    @(negedge i_clk);
    chk("pipe ack0", o_wb_ack, 1);
    chk("pipe write keeps data", o_wb_data, 32'd2);
    chk("pipe stall0", o_wb_stall, 0);
    i_wb_we   = 1'b0;
    i_wb_addr = 30'd3;
    @(negedge i_clk);
    chk("pipe ack1", o_wb_ack, 1);
    chk("pipe irq_en", o_wb_data, 32'hF);
    i_wb_addr = 30'd2;
    @(negedge i_clk);
    chk("pipe ack2", o_wb_ack, 1);
    chk("pipe status", o_wb_data, 32'd0);
    i_wb_addr = 30'd31;
    @(negedge i_clk);
    chk("pipe ack3", o_wb_ack, 1);
    chk("pipe addr31", o_wb_data, 32'd0);
    chk("pipe stall3", o_wb_stall, 0);
    i_wb_cyc = 1'b0;
    i_wb_stb = 1'b0;
    @(negedge i_clk);
    chk("pipe idle ack", o_wb_ack, 0);

    // Master drops cyc before the ack arrives
    i_wb_cyc  = 1'b1;
    i_wb_stb  = 1'b1;
    i_wb_addr = 30'd3;
    @(negedge i_clk);
    i_wb_cyc = 1'b0;
    i_wb_stb = 1'b0;
    #1;
    chk("abort ack", o_wb_ack, 0);
    @(negedge i_clk);

    // RELOAD=0 enable never fires
    wr(5'd17, 32'd0);
    wr(5'd16, 32'd1);
    repeat (400) @(negedge i_clk);
    rd_chk("reload0 status", 5'd2, 32'd0);
    rd_chk("reload0 ctrl2", 5'd16, 32'd1);
    rd_chk("reload0 count2", 5'd18, 32'd0);
    chk("reload0 irq", o_irq, 0);

    // Reset while a periodic channel runs and an ack is pending
    wr(5'd3, 32'd1);
    wr(5'd9, 32'd5);
    wr(5'd8, 32'd3);
    wait_irq("midrst", 40, n, x1);
    i_wb_cyc  = 1'b1;
    i_wb_stb  = 1'b1;
    i_wb_addr = 30'd10;
    @(negedge i_clk);
    chk("pending ack before rst", o_wb_ack, 1);
    i_wb_stb  = 1'b0;
    i_reset_n = 1'b0;
    #1;
    chk("midrst ack", o_wb_ack, 0);
    chk("midrst irq", o_irq, 0);
    chk("midrst data", o_wb_data, 0);
    i_wb_cyc = 1'b0;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    rd_chk("midrst status", 5'd2, 32'd0);
    rd_chk("midrst irq_en", 5'd3, 32'd0);
    rd_chk("midrst ctrl0", 5'd8, 32'd0);
    rd_chk("midrst reload0", 5'd9, 32'd0);
    rd_chk("midrst count0", 5'd10, 32'd0);
    rd_chk("midrst ctrl2", 5'd16, 32'd0);
    rd_chk("midrst now_hi", 5'd1, 32'd0);
    chk("midrst irq after", o_irq, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
